nms_2d: RTL
===========

NMS_2D -- requirements
Module: nms_2d

Interface
REQ-001 Parameter PIXEL_SCORE_DEPTH, default 13, bit width of every score.
REQ-002 Parameter IMG_WIDTH, default 640, pixels per line, minimum 3.
REQ-003 Parameter IMG_HEIGHT, default 480, lines per frame, minimum 3.
REQ-004 Parameter COORD_DEPTH, default 11, width of coordinate outputs; must hold IMG_WIDTH-1 and IMG_HEIGHT-1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  in_score and in_sof carry a pixel this cycle.
REQ-008 in_sof  input  1  qualified by in_valid; pixel is (0,0) of a new frame.
REQ-009 in_score  input  PIXEL_SCORE_DEPTH  raster-order corner score, unsigned.
REQ-010 out_valid  output  1  out_* carry one interior-pixel result.
REQ-011 out_score  output  PIXEL_SCORE_DEPTH  center score if kept, else 0.
REQ-012 out_x / out_y  output  COORD_DEPTH each  coordinate of the reported center.
REQ-013 out_eof  output  1  with out_valid; last result of frame, center (IMG_WIDTH-2, IMG_HEIGHT-2).

Function
REQ-014 3x3 non-maximum suppression on a raster stream, using two line buffers of IMG_WIDTH x PIXEL_SCORE_DEPTH plus a 3x3 window register.
REQ-015 No backpressure; in_valid gaps of any length allowed; state advances only on in_valid=1.
REQ-016 FSM states IDLE and ACTIVE; IDLE -> ACTIVE on in_valid&in_sof; ACTIVE -> IDLE after accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-017 In IDLE, in_valid with in_sof=0 is dropped: no counter, buffer or output change.
REQ-018 In ACTIVE, in_valid&in_sof restarts the frame: pixel taken as (0,0), counters reset, no result from the aborted frame emitted afterwards.
REQ-019 Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) track the accepted pixel; x wraps to 0 and y increments after x=IMG_WIDTH-1.
REQ-020 Accepted pixel (x,y) with x>=2 and y>=2 completes window centered at (x-1,y-1); exactly one result emitted for it.
REQ-021 Latency: result registered, out_valid high the cycle after the completing pixel is accepted; otherwise out_valid=0.
REQ-022 Kept when center >= every one of its 8 neighbours (ties keep, so equal neighbours may both be kept); otherwise out_score=0.
REQ-023 Border pixels (row 0, row IMG_HEIGHT-1, col 0, col IMG_WIDTH-1) produce no result; results per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
REQ-024 Comparisons unsigned, full PIXEL_SCORE_DEPTH; no saturation or truncation.
REQ-025 out_x, out_y, out_eof, out_score hold last values when out_valid=0.

Reset
REQ-026 While rst_n=0 at a clock edge: FSM=IDLE, x=y=0, window registers 0, out_valid=0, out_score=0, out_x=0, out_y=0, out_eof=0.
REQ-027 Line buffer contents need no reset; row gating (REQ-020) guarantees stale data never reaches a result.
REQ-028 Reset mid-frame discards the frame; next result requires a new in_sof.

Configuration
REQ-029 Macro NMS_2D_THRESHOLD_EN defined: extra input port in_threshold (PIXEL_SCORE_DEPTH) sampled per completing pixel; center kept only if REQ-022 holds and center >= in_threshold.
REQ-030 Macro NMS_2D_THRESHOLD_EN undefined: port absent, no threshold test, behaviour per REQ-022 only.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6)
REQ-031 Frame all zeros except (4,3)=100 -> 24 results; (4,3) out_score=100; all others 0; out_eof only on (6,4).
REQ-032 (3,2)=50 and (4,2)=50 adjacent, rest 10 -> both results 50 (tie kept); their other neighbours report 0.
REQ-033 Pixel (5,2) completing center (4,1), in_valid low 3 cycles before it -> out_valid exactly one cycle after that pixel is accepted, out_x=4, out_y=1.
REQ-034 in_sof re-asserted at pixel (3,4) of frame 1, then full frame 2 -> no result from frame 1 after restart; frame 2 gives 24 results with correct coordinates.
REQ-035 rst_n low 2 cycles mid-frame, then non-sof pixels, then full frame -> all outputs 0 during reset, non-sof pixels dropped, full frame gives 24 results.
REQ-036 With NMS_2D_THRESHOLD_EN, in_threshold=60, isolated peaks 50 and 70 -> peak 70 reported, peak 50 reported as 0.

Source files
------------

// File: rtl/nms_2d.sv
// 3x3 non-maximum suppression over a raster score stream, with two line buffers and a 3x3 window.
// Optional macro NMS_2D_THRESHOLD_EN adds an in_threshold port that results must also meet.
module nms_2d #(
    parameter int PIXEL_SCORE_DEPTH = 13,
    parameter int IMG_WIDTH         = 640,
    parameter int IMG_HEIGHT        = 480,
    parameter int COORD_DEPTH       = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [PIXEL_SCORE_DEPTH-1:0] in_score,
`ifdef NMS_2D_THRESHOLD_EN
    input  logic [PIXEL_SCORE_DEPTH-1:0] in_threshold,
`endif
    output logic                         out_valid,
    output logic [PIXEL_SCORE_DEPTH-1:0] out_score,
    output logic [COORD_DEPTH-1:0]       out_x,
    output logic [COORD_DEPTH-1:0]       out_y,
    output logic                         out_eof
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [COORD_DEPTH-1:0] X_LAST = COORD_DEPTH'(IMG_WIDTH - 1);
    localparam logic [COORD_DEPTH-1:0] Y_LAST = COORD_DEPTH'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                       state;
    logic [COORD_DEPTH-1:0]       x_cnt;
    logic [COORD_DEPTH-1:0]       y_cnt;
    logic [PIXEL_SCORE_DEPTH-1:0] line0 [IMG_WIDTH];
    logic [PIXEL_SCORE_DEPTH-1:0] line1 [IMG_WIDTH];
    logic [PIXEL_SCORE_DEPTH-1:0] col_a [3];
    logic [PIXEL_SCORE_DEPTH-1:0] col_b [3];
    logic [PIXEL_SCORE_DEPTH-1:0] col_c [3];
    logic [PIXEL_SCORE_DEPTH-1:0] center;
    logic                         accept;
    logic                         completes;
    logic                         is_max;
    logic                         keep;
    logic [COORD_DEPTH-1:0]       cur_x;
    logic [COORD_DEPTH-1:0]       cur_y;
    logic [AW-1:0]                lb_addr;

    // A start-of-frame pixel is always position (0,0), even when it aborts a frame in progress.
    always_comb begin
        accept    = in_valid && (in_sof || state == ACTIVE);
        cur_x     = in_sof ? '0 : x_cnt;
        cur_y     = in_sof ? '0 : y_cnt;
        lb_addr   = cur_x[AW-1:0];
        col_c[0]  = line1[lb_addr];
        col_c[1]  = line0[lb_addr];
        col_c[2]  = in_score;
        center    = col_b[1];
        is_max    = (center >= col_a[0]) && (center >= col_a[1]) && (center >= col_a[2]) &&
                    (center >= col_b[0]) && (center >= col_b[2]) &&
                    (center >= col_c[0]) && (center >= col_c[1]) && (center >= col_c[2]);
`ifdef NMS_2D_THRESHOLD_EN
        keep      = is_max && (center >= in_threshold);
`else
        keep      = is_max;
`endif
        completes = accept && (cur_x >= COORD_DEPTH'(2)) && (cur_y >= COORD_DEPTH'(2));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line1[lb_addr] <= line0[lb_addr];
            line0[lb_addr] <= in_score;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            out_valid <= 1'b0;
            out_score <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_eof   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                col_a[i] <= '0;
                col_b[i] <= '0;
            end
        end else begin
            out_valid <= completes;
            if (accept) begin
                if (cur_x == X_LAST) begin
                    x_cnt <= '0;
                    if (cur_y == Y_LAST) begin
                        y_cnt <= '0;
                        state <= IDLE;
                    end else begin
                        y_cnt <= cur_y + COORD_DEPTH'(1);
                        state <= ACTIVE;
                    end
                end else begin
                    x_cnt <= cur_x + COORD_DEPTH'(1);
                    y_cnt <= cur_y;
                    state <= ACTIVE;
                end
                for (int i = 0; i < 3; i++) begin
                    col_a[i] <= col_b[i];
                    col_b[i] <= col_c[i];
                end
            end
            if (completes) begin
                out_score <= keep ? center : '0;
                out_x     <= cur_x - COORD_DEPTH'(1);
                out_y     <= cur_y - COORD_DEPTH'(1);
                out_eof   <= (cur_x == X_LAST) && (cur_y == Y_LAST);
            end
        end
    end

endmodule
